// File: rtl/pwm_sample_decoder_if.sv
// Signal bundle for the PWM sample decoder.
// The decoder uses the slave modport. The PWM source or test driver uses the master modport.
interface pwm_sample_decoder_if;
    logic       pwm_in;
    logic [7:0] sample;
    logic       sample_valid;
    logic       locked;
    logic       error;

    modport master (
        output pwm_in,
        input  sample,
        input  sample_valid,
        input  locked,
        input  error
    );

    modport slave (
        input  pwm_in,
        output sample,
        output sample_valid,
        output locked,
        output error
    );
endinterface

// File: rtl/pwm_sample_decoder.sv
// Recovers 8-bit samples from a PWM stream by measuring the high time between rising edges.
// Define PWM_DEC_GLITCH_FILTER_EN to enable a 3-tap majority filter after the synchroniser.
module pwm_sample_decoder #(
    parameter int PERIOD = 255,
    parameter int TOL    = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    pwm_sample_decoder_if.slave bus
);

    localparam int             CNT_W   = $clog2(PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] P_LO    = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] P_HI    = CNT_W'(PERIOD + TOL);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_pwm_s;
    logic             r_pwm_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic             r_have_edge;
    logic [7:0]       r_sample;
    logic             r_valid;
    logic             r_locked;
    logic             r_error;

    logic             w_lvl;
    logic             w_timeout;
    logic             w_in_tol;
    logic [7:0]       w_high_clip;

    // NOTE: the reset here is synchronous, so it sits inside the clocked branch and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic [2:0] r_filt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= 3'b000;
        end else begin
            r_filt <= {r_filt[1:0], r_sync2};
        end
    end

    // The majority of three taps rejects any single-clock pulse or gap.
    assign w_pwm_s = (r_filt[0] & r_filt[1]) | (r_filt[0] & r_filt[2]) | (r_filt[1] & r_filt[2]);
`else
    assign w_pwm_s = r_sync2;
`endif

    // The edge is registered, so r_pwm_d is the line level at the same stage as r_rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_d <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_pwm_d <= w_pwm_s;
            r_rise  <= w_pwm_s & ~r_pwm_d;
        end
    end

    assign w_lvl       = r_pwm_d;
    assign w_timeout   = !r_rise && (r_period_cnt == P_HI);
    assign w_in_tol    = (r_period_cnt >= P_LO) && (r_period_cnt <= P_HI);
    assign w_high_clip = (r_high_cnt > CNT_W'(255)) ? 8'd255 : 8'(r_high_cnt);

    // A rising edge closes a frame. When no edge arrives for PERIOD+TOL clocks, the line is treated as a constant level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_have_edge  <= 1'b0;
            r_sample     <= 8'd0;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // NOTE: every state update uses <=, so all branches read the counter values from before this edge.
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (r_rise) begin
                r_period_cnt <= CNT_ONE;
                r_high_cnt   <= CNT_ONE;
                r_have_edge  <= 1'b1;
                if (r_have_edge) begin
                    if (w_in_tol) begin
                        r_sample <= w_high_clip;
                        r_valid  <= 1'b1;
                        r_locked <= 1'b1;
                    end else begin
                        r_error  <= 1'b1;
                        r_locked <= 1'b0;
                    end
                end
            end else if (w_timeout) begin
                r_sample     <= w_lvl ? 8'd255 : 8'd0;
                r_valid      <= 1'b1;
                r_locked     <= 1'b1;
                r_period_cnt <= CNT_ONE;
                r_high_cnt   <= {{(CNT_W-1){1'b0}}, w_lvl};
                r_have_edge  <= 1'b0;
            end else begin
                if (r_period_cnt != CNT_MAX) begin
                    r_period_cnt <= r_period_cnt + CNT_ONE;
                end
                if (r_high_cnt != CNT_MAX) begin
                    r_high_cnt <= r_high_cnt + {{(CNT_W-1){1'b0}}, w_lvl};
                end
            end
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.locked       = r_locked;
    assign bus.error        = r_error;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed bench for pwm_sample_decoder (default build, PERIOD=255, TOL=1).
// Inputs are driven and outputs are sampled 1 time unit after each rising clock edge.
module tb_pwm_sample_decoder;

    logic clk;
    logic rst_n;

    pwm_sample_decoder_if bus ();

    pwm_sample_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid, n_err, n_both;
    int first_v, last_v, prev_v, last_s, prev_s;
    bit t5_mode = 1'b0;
    int t5_exp  = 0;
    int f0, t4, v0, w0, r0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance, then record the output pulses seen after this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.sample_valid) begin
            n_valid++;
            prev_v = last_v;
            last_v = cyc;
            if (first_v < 0) first_v = cyc;
            prev_s = last_s;
            last_s = int'(bus.sample);
            if (t5_mode) begin
                check("t5_sample", 32'(bus.sample), 32'(t5_exp));
                t5_exp++;
            end
        end
        if (bus.error) n_err++;
        if (bus.sample_valid && bus.error) n_both++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic win_clear();
        n_valid = 0;
        n_err   = 0;
        first_v = -1;
        last_v  = -1;
        prev_v  = -1;
    endtask

    task automatic frame(input int per, input int hi);
        for (int i = 0; i < per; i++) begin
            bus.pwm_in = (i < hi);
            tick();
        end
    endtask

    initial begin
        n_both = 0;
        win_clear();
        last_s = -1;
        prev_s = -1;

        // 1: reset while the input toggles
        rst_n      = 1'b0;
        bus.pwm_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pwm_in = ~bus.pwm_in;
            tick();
        end
        check("rst_sample", 32'(bus.sample), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        bus.pwm_in = 1'b0;
        rst_n      = 1'b1;
        ticks(10);

        // 2: five nominal frames with 100 high clocks; the first rise only arms
        win_clear();
        f0 = cyc;
        for (int k = 0; k < 5; k++) frame(255, 100);
        check("t2_nvalid", 32'(n_valid), 32'd4);
        check("t2_first_valid_cyc", 32'(first_v), 32'(f0 + 255 + 4));
        check("t2_spacing", 32'(last_v - prev_v), 32'd255);
        check("t2_sample", 32'(last_s), 32'd100);
        check("t2_locked", 32'(bus.locked), 32'd1);
        check("t2_nerr", 32'(n_err), 32'd0);

        // 4: period 200; the first rise closes the last 255-clock frame
        win_clear();
        t4 = cyc;
        for (int k = 0; k < 5; k++) frame(200, 50);
        check("t4_nvalid", 32'(n_valid), 32'd1);
        check("t4_valid_cyc", 32'(first_v), 32'(t4 + 4));
        check("t4_nerr", 32'(n_err), 32'd4);
        check("t4_locked", 32'(bus.locked), 32'd0);
        check("t4_sample_held", 32'(bus.sample), 32'd100);

        // 4b: periods 254 and 256 fall inside the tolerance window
        win_clear();
        frame(254, 60);
        frame(256, 70);
        v0         = cyc;
        bus.pwm_in = 1'b1;
        ticks(5);
        check("t4b_nerr", 32'(n_err), 32'd1);
        check("t4b_nvalid", 32'(n_valid), 32'd2);
        check("t4b_sample_254", 32'(prev_s), 32'd60);
        check("t4b_sample_256", 32'(last_s), 32'd70);
        check("t4b_locked", 32'(bus.locked), 32'd1);

        // 3: constant high, then constant low, decoded through the timeout path
        win_clear();
        ticks(995);
        check("t3h_nvalid", 32'(n_valid), 32'd3);
        check("t3h_first_cyc", 32'(first_v), 32'(v0 + 260));
        check("t3h_spacing", 32'(last_v - prev_v), 32'd256);
        check("t3h_sample", 32'(last_s), 32'd255);
        check("t3h_locked", 32'(bus.locked), 32'd1);
        check("t3h_nerr", 32'(n_err), 32'd0);

        win_clear();
        w0         = cyc;
        bus.pwm_in = 1'b0;
        ticks(1000);
        check("t3l_nvalid", 32'(n_valid), 32'd4);
        check("t3l_first_cyc", 32'(first_v), 32'(w0 + 28));
        check("t3l_spacing", 32'(last_v - prev_v), 32'd256);
        check("t3l_sample", 32'(last_s), 32'd0);
        check("t3l_nerr", 32'(n_err), 32'd0);

        // 5: duty ramp 0..255; expect 0 (timeout), 1..254, then 255 (timeout)
        win_clear();
        t5_mode = 1'b1;
        t5_exp  = 0;
        for (int s = 0; s < 256; s++) frame(255, s);
        bus.pwm_in = 1'b1;
        ticks(200);
        t5_mode = 1'b0;
        check("t5_nvalid", 32'(n_valid), 32'd256);
        check("t5_last_sample", 32'(last_s), 32'd255);
        check("t5_nerr", 32'(n_err), 32'd0);

        // 6: reset 80 clocks into the high phase of a frame
        bus.pwm_in = 1'b0;
        ticks(50);
        bus.pwm_in = 1'b1;
        ticks(80);
        bus.pwm_in = 1'b0;
        rst_n      = 1'b0;
        ticks(2);
        check("t6_rst_sample", 32'(bus.sample), 32'd0);
        check("t6_rst_valid", 32'(bus.sample_valid), 32'd0);
        check("t6_rst_locked", 32'(bus.locked), 32'd0);
        check("t6_rst_error", 32'(bus.error), 32'd0);
        rst_n = 1'b1;
        ticks(10);
        win_clear();
        r0 = cyc;
        frame(255, 100);
        frame(255, 100);
        check("t6_nvalid", 32'(n_valid), 32'd1);
        check("t6_valid_cyc", 32'(first_v), 32'(r0 + 255 + 4));
        check("t6_sample", 32'(last_s), 32'd100);
        check("t6_nerr", 32'(n_err), 32'd0);

        check("valid_and_error_overlap", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
